operand_entry: RTL and testbench

Parametrised operand entry unit for the calculator datapath. It generalises the two-operand, increment-only entry logic to `NUM_OPERANDS` operands of `WIDTH` bits. It adds on-chip synchronisation and debouncing of the buttons, a decrement button, and a wrap or saturate arithmetic mode. It sits between the board push-buttons and the ALU/display blocks. Its packed operand bus feeds the ALU operand inputs and the seven-segment/VGA formatters.

---
 rtl/operand_entry.sv | 158 +++++++++++++++
 tb/tb_operand_entry.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// Operand entry unit: four synchronised, debounced buttons drive editing of
// NUM_OPERANDS operands of WIDTH bits, with wrap or saturate arithmetic.
module operand_entry #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned NUM_OPERANDS    = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned SATURATE        = 0,
    parameter int unsigned LED_CYCLES      = 4,
    localparam int unsigned TW = (NUM_OPERANDS > 2) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                          in_clk,
    input  logic                          resetN,
    input  logic                          incrementBtn,
    input  logic                          decrementBtn,
    input  logic                          saveBtn,
    input  logic                          clearBtn,
    output logic [NUM_OPERANDS*WIDTH-1:0] operands,
    output logic [TW-1:0]                 target,
    output logic                          allEntered,
    output logic                          pressPulse,
    output logic                          btnPressLED
);

    localparam int unsigned NB   = 4;
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LW   = $clog2(LED_CYCLES + 1);
    localparam int unsigned BINC = 0;
    localparam int unsigned BDEC = 1;
    localparam int unsigned BSAV = 2;
    localparam int unsigned BCLR = 3;
    localparam logic [TW-1:0] LAST = TW'(NUM_OPERANDS - 1);

    typedef enum logic {
        ST_ENTRY,
        ST_DONE
    } state_t;

    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_db;
    logic [NB-1:0] r_db_q;
    logic [CW-1:0] r_cnt [NB];
    logic [NB-1:0] w_evt;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [NUM_OPERANDS*WIDTH-1:0] r_operands;
    logic [NUM_OPERANDS*WIDTH-1:0] w_operands_nxt;
    logic [TW-1:0]                 r_target;
    logic [TW-1:0]                 w_target_nxt;
    logic [WIDTH-1:0]              w_cur;
    logic [WIDTH-1:0]              w_new;
    logic                          w_accept;
    logic                          r_pulse;
    logic [LW-1:0]                 r_led;
    logic [LW-1:0]                 w_led_nxt;

    assign w_raw = {clearBtn, saveBtn, decrementBtn, incrementBtn};
    assign w_evt = r_db & ~r_db_q;

    // Debounced level flips only once the counter has already reached the limit.
    always_ff @(posedge in_clk or negedge resetN) begin
        if (!resetN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_operands_nxt = r_operands;
        w_target_nxt   = r_target;
        w_accept       = 1'b0;
        w_cur          = r_operands[r_target*WIDTH +: WIDTH];
        w_new          = w_cur;

        if (w_evt[BCLR]) begin
            w_accept       = 1'b1;
            w_operands_nxt = '0;
            w_target_nxt   = '0;
            w_state_nxt    = ST_ENTRY;
        end else if (w_evt[BSAV]) begin
            w_accept = 1'b1;
            if (r_state == ST_DONE) begin
                w_target_nxt = '0;
                w_state_nxt  = ST_ENTRY;
            end else if (r_target == LAST) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_target_nxt = r_target + 1'b1;
            end
        end else if ((w_evt[BINC] || w_evt[BDEC]) && r_state == ST_ENTRY) begin
            // Increment outranks decrement; a same-cycle decrement is dropped.
            w_accept = 1'b1;
            if (w_evt[BINC]) begin
                if (!(SATURATE != 0 && w_cur == '1)) begin
                    w_new = w_cur + 1'b1;
                end
            end else begin
                if (!(SATURATE != 0 && w_cur == '0)) begin
                    w_new = w_cur - 1'b1;
                end
            end
            w_operands_nxt[r_target*WIDTH +: WIDTH] = w_new;
        end

        if (w_accept) begin
            w_led_nxt = LW'(LED_CYCLES);
        end else if (r_led != '0) begin
            w_led_nxt = r_led - 1'b1;
        end else begin
            w_led_nxt = r_led;
        end
    end

    always_ff @(posedge in_clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_ENTRY;
            r_operands <= '0;
            r_target   <= '0;
            r_pulse    <= 1'b0;
            r_led      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_operands <= w_operands_nxt;
            r_target   <= w_target_nxt;
            r_pulse    <= w_accept;
            r_led      <= w_led_nxt;
        end
    end

    assign operands    = r_operands;
    assign target      = r_target;
    assign allEntered  = (r_state == ST_DONE);
    assign pressPulse  = r_pulse;
    assign btnPressLED = (r_led != '0);

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: a wrap instance and a saturate instance, with a
// per-instance scoreboard of expected state popped on every pressPulse.
module tb_operand_entry;

    localparam int W    = 4;
    localparam int N    = 2;
    localparam int D    = 2;
    localparam int LEDC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] b0    = '0;   // {clear, save, dec, inc}
    logic [3:0] b1    = '0;
    logic [7:0] ops0, ops1;
    logic       tgt0, tgt1, all0, all1, pp0, pp1, led0, led1;

    operand_entry #(.WIDTH(W), .NUM_OPERANDS(N), .DEBOUNCE_CYCLES(D), .SATURATE(0), .LED_CYCLES(LEDC)) u_wrap (
        .in_clk(clk), .resetN(rst_n),
        .incrementBtn(b0[0]), .decrementBtn(b0[1]), .saveBtn(b0[2]), .clearBtn(b0[3]),
        .operands(ops0), .target(tgt0), .allEntered(all0), .pressPulse(pp0), .btnPressLED(led0)
    );

    operand_entry #(.WIDTH(W), .NUM_OPERANDS(N), .DEBOUNCE_CYCLES(D), .SATURATE(1), .LED_CYCLES(LEDC)) u_sat (
        .in_clk(clk), .resetN(rst_n),
        .incrementBtn(b1[0]), .decrementBtn(b1[1]), .saveBtn(b1[2]), .clearBtn(b1[3]),
        .operands(ops1), .target(tgt1), .allEntered(all1), .pressPulse(pp1), .btnPressLED(led1)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         pulses [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] e0, e1;
    logic [7:0] m_ops [2];
    logic       m_tgt [2];
    logic       m_all [2];

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && pp0) begin
            pulses[0]++;
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL sb_wrap: unexpected pulse, got ops=%h tgt=%0d all=%0b, expected none", ops0, tgt0, all0);
            end else begin
                e0 = q0.pop_front();
                if ({ops0, tgt0, all0} !== e0) begin
                    n_fail++;
                    $display("FAIL sb_wrap: got {ops,tgt,all}=%h expected %h", {ops0, tgt0, all0}, e0);
                end
            end
        end
        if (rst_n && pp1) begin
            pulses[1]++;
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL sb_sat: unexpected pulse, got ops=%h tgt=%0d all=%0b, expected none", ops1, tgt1, all1);
            end else begin
                e1 = q1.pop_front();
                if ({ops1, tgt1, all1} !== e1) begin
                    n_fail++;
                    $display("FAIL sb_sat: got {ops,tgt,all}=%h expected %h", {ops1, tgt1, all1}, e1);
                end
            end
        end
    end

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ops[d] = '0;
            m_tgt[d] = 1'b0;
            m_all[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference behaviour for one button event mask on instance d (1 = saturate).
    task automatic model_apply(input int d, input logic [3:0] m);
        logic [3:0] cur;
        logic       acc;
        acc = 1'b1;
        if (m[3]) begin
            m_ops[d] = '0;
            m_tgt[d] = 1'b0;
            m_all[d] = 1'b0;
        end else if (m[2]) begin
            if (m_all[d]) begin
                m_tgt[d] = 1'b0;
                m_all[d] = 1'b0;
            end else if (m_tgt[d] == 1'b1) begin
                m_all[d] = 1'b1;
            end else begin
                m_tgt[d] = 1'b1;
            end
        end else if ((m[0] || m[1]) && !m_all[d]) begin
            cur = m_tgt[d] ? m_ops[d][7:4] : m_ops[d][3:0];
            if (m[0]) cur = (d == 1 && cur == 4'hF) ? cur : cur + 4'd1;
            else      cur = (d == 1 && cur == 4'h0) ? cur : cur - 4'd1;
            if (m_tgt[d]) m_ops[d][7:4] = cur;
            else          m_ops[d][3:0] = cur;
        end else begin
            acc = 1'b0;
        end
        if (acc) begin
            if (d == 0) q0.push_back({m_ops[0], m_tgt[0], m_all[0]});
            else        q1.push_back({m_ops[1], m_tgt[1], m_all[1]});
        end
    endtask

    task automatic press(input int d, input logic [3:0] m, input int hold, input int rel);
        model_apply(d, m);
        @(posedge clk); #1;
        if (d == 0) b0 = m; else b1 = m;
        repeat (hold) @(posedge clk);
        #1;
        if (d == 0) b0 = '0; else b1 = '0;
        repeat (rel) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if ({ops0, tgt0, all0, pp0, led0} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_wrap: got %h expected 000", {ops0, tgt0, all0, pp0, led0});
        end
        n_checks++;
        if ({ops1, tgt1, all1, pp1, led1} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_sat: got %h expected 000", {ops1, tgt1, all1, pp1, led1});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_entry();
        repeat (4) press(0, 4'b0001, 10, 10);
        n_checks++;
        if (ops0 !== 8'h04) begin n_fail++; $display("FAIL basic_inc4: got %h expected 04", ops0); end
        press(0, 4'b0100, 10, 10);
        n_checks++;
        if (tgt0 !== 1'b1) begin n_fail++; $display("FAIL basic_save: got target %0d expected 1", tgt0); end
        press(0, 4'b0001, 10, 10);
        n_checks++;
        if ({ops0, all0} !== {8'h14, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_op1: got ops=%h all=%0b expected 14/0", ops0, all0);
        end
    endtask

    task automatic test_clear();
        int np, nl, fp, fl;
        np = 0; nl = 0; fp = -1; fl = -1;
        model_apply(0, 4'b1000);
        @(posedge clk); #1 b0 = 4'b1000;
        // Iteration 1 follows the edge that first samples the press.
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (pp0)  begin np++; if (fp < 0) fp = c; end
            if (led0) begin nl++; if (fl < 0) fl = c; end
            if (c == 10) b0 = '0;
        end
        n_checks++;
        if (np !== 1) begin n_fail++; $display("FAIL clear_pulse_len: got %0d expected 1", np); end
        n_checks++;
        if (fp !== D + 4) begin n_fail++; $display("FAIL clear_pulse_start: got %0d expected %0d", fp, D + 4); end
        n_checks++;
        if (nl !== LEDC) begin n_fail++; $display("FAIL clear_led_len: got %0d expected %0d", nl, LEDC); end
        n_checks++;
        if (fl !== D + 4) begin n_fail++; $display("FAIL clear_led_start: got %0d expected %0d", fl, D + 4); end
        n_checks++;
        if ({ops0, tgt0, all0} !== 10'h000) begin
            n_fail++;
            $display("FAIL clear_state: got %h expected 000", {ops0, tgt0, all0});
        end
    endtask

    task automatic test_arith();
        int p;
        press(0, 4'b0010, 10, 10);
        n_checks++;
        if (ops0 !== 8'h0F) begin n_fail++; $display("FAIL wrap_dec: got %h expected 0F", ops0); end
        press(0, 4'b0001, 10, 10);
        n_checks++;
        if (ops0 !== 8'h00) begin n_fail++; $display("FAIL wrap_inc: got %h expected 00", ops0); end
        p = pulses[1];
        press(1, 4'b0010, 10, 10);
        n_checks++;
        if (ops1 !== 8'h00) begin n_fail++; $display("FAIL sat_dec: got %h expected 00", ops1); end
        repeat (17) press(1, 4'b0001, 10, 10);
        n_checks++;
        if (ops1 !== 8'h0F) begin n_fail++; $display("FAIL sat_inc17: got %h expected 0F", ops1); end
        n_checks++;
        if (pulses[1] - p !== 18) begin
            n_fail++;
            $display("FAIL sat_pulses: got %0d expected 18", pulses[1] - p);
        end
    endtask

    task automatic test_debounce();
        int p;
        p = pulses[0];
        @(posedge clk); #1 b0 = 4'b0001;
        @(posedge clk); #1 b0 = '0;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (pulses[0] !== p || ops0 !== 8'h00) begin
            n_fail++;
            $display("FAIL glitch: got ops=%h pulses=%0d expected 00/0", ops0, pulses[0] - p);
        end
        press(0, 4'b0001, 200, 10);
        n_checks++;
        if (ops0 !== 8'h01) begin n_fail++; $display("FAIL held200: got %h expected 01", ops0); end
        p = pulses[0];
        model_apply(0, 4'b0001);
        @(posedge clk); #1 b0 = 4'b0001;
        @(posedge clk); #1 b0 = 4'b0000;
        @(posedge clk); #1 b0 = 4'b0001;
        @(posedge clk); #1 b0 = 4'b0000;
        @(posedge clk); #1 b0 = 4'b0001;
        repeat (10) @(posedge clk);
        #1 b0 = '0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (ops0 !== 8'h02 || pulses[0] - p !== 1) begin
            n_fail++;
            $display("FAIL bouncy: got ops=%h pulses=%0d expected 02/1", ops0, pulses[0] - p);
        end
    endtask

    task automatic test_all_entered();
        int p;
        press(0, 4'b0100, 10, 10);
        press(0, 4'b0100, 10, 10);
        n_checks++;
        if ({tgt0, all0} !== 2'b11) begin
            n_fail++;
            $display("FAIL all_set: got tgt=%0d all=%0b expected 1/1", tgt0, all0);
        end
        p = pulses[0];
        press(0, 4'b0001, 10, 10);
        n_checks++;
        if (ops0 !== 8'h02 || pulses[0] !== p) begin
            n_fail++;
            $display("FAIL all_inc_ignored: got ops=%h pulses=%0d expected 02/0", ops0, pulses[0] - p);
        end
        press(0, 4'b0100, 10, 10);
        n_checks++;
        if ({ops0, tgt0, all0} !== {8'h02, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL all_release: got %h expected %h", {ops0, tgt0, all0}, {8'h02, 2'b00});
        end
    endtask

    task automatic test_priority();
        int p;
        press(0, 4'b1000, 10, 10);
        repeat (5) press(0, 4'b0001, 10, 10);
        n_checks++;
        if (ops0 !== 8'h05) begin n_fail++; $display("FAIL prio_setup: got %h expected 05", ops0); end
        p = pulses[0];
        press(0, 4'b1001, 10, 10);
        n_checks++;
        if (ops0 !== 8'h00 || pulses[0] - p !== 1) begin
            n_fail++;
            $display("FAIL prio_clear_inc: got ops=%h pulses=%0d expected 00/1", ops0, pulses[0] - p);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) press(0, 4'b0001, 10, 10);
        @(posedge clk); #1 b0 = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ops0, tgt0, all0, pp0, led0} !== 12'h000 || ops1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got wrap=%h sat_ops=%h expected 000/00", {ops0, tgt0, all0, pp0, led0}, ops1);
        end
        model_reset();
        repeat (2) @(posedge clk);
        model_apply(0, 4'b0001);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c == D + 3) begin
                n_checks++;
                if (ops0 !== 8'h00) begin n_fail++; $display("FAIL post_reset_early: got %h expected 00", ops0); end
            end
            if (c == D + 4) begin
                n_checks++;
                if (ops0 !== 8'h01) begin n_fail++; $display("FAIL post_reset_inc: got %h expected 01", ops0); end
            end
        end
        b0 = '0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        pulses[0] = 0;
        pulses[1] = 0;
        test_reset();
        test_basic_entry();
        test_clear();
        test_arith();
        test_debounce();
        test_all_entered();
        test_priority();
        test_reset_mid();
        for (int i = 0; i < 50; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d outstanding expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
